// File: rtl/arith_pkg.sv
// Shared constants for the byte-serial arithmetic blocks.
//   ST_IDLE / ST_RUN : packet state encoding (no packet open / packet open)
//   OP_ADD / OP_SUB  : operation select carried on in_sub
package arith_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int unsigned DATA_W = 8;

endpackage

// File: rtl/adder8bit.sv
// Combinational 8-bit ripple adder with carry in/out.
//   a, b : operand bytes
//   cin  : carry in
//   sum  : result byte
//   cout : carry out
module adder8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/serial_byte_adder.sv
// Byte-serial multi-precision add/subtract controller around adder8bit.
// Operand byte pairs arrive LSB first over valid/ready; the carry is chained
// between bytes in a register and each result byte is held in a single-entry
// output register.
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : input handshake
//   in_a, in_b                 : operand bytes
//   in_first, in_last, in_sub  : packet framing and operation (sub sampled on first)
//   out_valid/out_ready        : output handshake
//   out_sum, out_cout, out_ovf : result byte, carry out, signed overflow (MSB only)
//   out_last, out_idx          : MSB marker and byte index of the result
//   err                        : one-cycle pulse on a protocol error
module serial_byte_adder
  import arith_pkg::*;
#(
  parameter  int unsigned MAX_BYTES = 8,
  localparam int unsigned IDXW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_a,
  input  logic [7:0]      in_b,
  input  logic            in_first,
  input  logic            in_last,
  input  logic            in_sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_sum,
  output logic            out_cout,
  output logic            out_ovf,
  output logic            out_last,
  output logic [IDXW-1:0] out_idx,
  output logic            err
);

  logic            r_state;
  logic            r_carry;
  logic            r_sub;
  logic [IDXW-1:0] r_idx;

  logic            r_out_valid;
  logic [7:0]      r_out_sum;
  logic            r_out_cout;
  logic            r_out_ovf;
  logic            r_out_last;
  logic [IDXW-1:0] r_out_idx;

  logic            w_accept;
  logic            w_start;
  logic            w_sub;
  logic            w_cin;
  logic [IDXW-1:0] w_idx;
  logic [7:0]      w_b_eff;
  logic [7:0]      w_sum;
  logic            w_cout;
  logic            w_force_last;
  logic            w_last;
  logic            w_ovf;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // A byte in IDLE always opens a packet, even without in_first.
  assign w_start = (r_state == ST_IDLE) || in_first;
  assign w_sub   = w_start ? in_sub : r_sub;
  assign w_cin   = w_start ? in_sub : r_carry;
  assign w_idx   = w_start ? '0 : r_idx + 1'b1;
  assign w_b_eff = (w_sub == OP_SUB) ? ~in_b : in_b;

  adder8bit u_adder (
    .a    (in_a),
    .b    (w_b_eff),
    .cin  (w_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // A packet that reaches the last index without in_last is closed here.
  assign w_force_last = (w_idx == IDXW'(MAX_BYTES - 1)) && !in_last;
  assign w_last       = in_last || w_force_last;
  assign w_ovf        = w_last && (in_a[7] == w_b_eff[7]) && (w_sum[7] != in_a[7]);

  assign err = w_accept && (((r_state == ST_IDLE) && !in_first) ||
                            ((r_state == ST_RUN) && in_first) ||
                            w_force_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_state <= w_last ? ST_IDLE : ST_RUN;
      r_carry <= w_cout;
      r_sub   <= w_sub;
      r_idx   <= w_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= 8'h00;
      r_out_cout  <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_sum   <= w_sum;
      r_out_cout  <= w_cout;
      r_out_ovf   <= w_ovf;
      r_out_last  <= w_last;
      r_out_idx   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign out_ovf   = r_out_ovf;
  assign out_last  = r_out_last;
  assign out_idx   = r_out_idx;

endmodule
